vec_mem_sequencer: RTL and testbench
====================================

// Module: vec_mem_sequencer
// PURPOSE
//  Sequences vector instructions (VLD 4'b1100, VST 4'b1101, VDOT 4'b1110) over the single shared
//  16-bit memory port, one element per granted request. Holds a VLEN-entry vector register file.
//  Sits beside the x/x2 execute pipe. The front end stalls on ins_ready=0 while an op is in flight.
//  Element addresses are byte-addressed with a stride of 2.
// PARAMETERS
//  VLEN    4   elements per vector op (>=2); counters are $clog2(VLEN)+1 bits
//  DATA_W  16  element / memory data width
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst_n       in   1      synchronous active-low reset; one clock, sync active-low reset
//  ins_valid   in   1      instruction offered
//  ins_ready   out  1      sequencer can accept (IDLE only)
//  ins         in   16     instruction; opcode = ins[15:12]
//  base_addr   in   16     vector base byte address (operand_1)
//  mem_req     out  1      memory request
//  mem_we      out  1      1=write (VST), 0=read
//  mem_addr    out  16     base_addr + 2*idx, mod 2^16
//  mem_wdata   out  16     vreg[idx] during VST, else 0
//  mem_gnt     in   1      request accepted this cycle
//  mem_rvalid  in   1      read data valid; returns in request order
//  mem_rdata   in   16     read data
//  done        out  1      1-cycle completion pulse
//  result      out  16     VDOT sum, valid with done; 0 for other ops
//  illegal     out  1      with done: opcode was not a vector op
//  vreg_sel    in   $clog2(VLEN)  debug read select
//  vreg_data   out  16     vreg[vreg_sel], combinational
// BEHAVIOUR
//  Reset: state=IDLE, vreg[*]=0, acc=0, idx=0, ret=0, outstanding=0.
//   Outputs: mem_req=0, mem_we=0, done=0, result=0, illegal=0. ins_ready=1 in the first cycle after reset.
//  Reset mid-op: abandons the op at once. Any later mem_rvalid is ignored until the next accept.
//  States: IDLE, ISSUE, DRAIN, DONE.
//  IDLE: ins_ready=1. An instruction is accepted when ins_valid && ins_ready.
//   - Vector opcode: latch op and base_addr, clear idx/ret/acc, go to ISSUE.
//   - Any other opcode: go to DONE with illegal=1 and result=0.
//  ISSUE: mem_req=1. addr, we and wdata are driven from the latched op and idx.
//   They hold stable until mem_gnt. Each grant increments idx.
//   A granted read increments outstanding.
//   Grant of element VLEN-1: VST goes to DONE; VLD/VDOT go to DRAIN.
//  mem_rvalid in ISSUE or DRAIN, element ret:
//   - VLD: vreg[ret] <= rdata.
//   - VDOT: acc <= acc + rdata*vreg[ret], keeping the low 16 bits only.
//   Then ret++ and outstanding--.
//   A same-cycle grant and rvalid leaves outstanding unchanged.
//  DRAIN: mem_req=0. Go to DONE on the cycle the last rvalid is consumed (ret reaching VLEN).
//  DONE: done=1, result=acc (VDOT) else 0, ins_ready=0, then IDLE.
//   done, result and illegal are registered and are 0 outside DONE.
//  mem_rvalid is ignored in IDLE and DONE.
//  Latency (gnt held 1, rvalid 2 cycles after gnt, accept at cycle T, VLEN=4):
//   - VLD/VDOT: grants T+1..T+4, done at T+7.
//   - VST: done at T+5.
//   - Illegal opcode: done at T+1.
//  ins_ready=0 from ISSUE through DONE, so no op can overlap another.
//   Back-to-back ops: next accept in the IDLE cycle after DONE.
// TESTING
//  1 VLD ins=0xC000, base=0x0100, gnt=1, rdata 0x11,0x22,0x33,0x44
//    -> addr 0x100,0x102,0x104,0x106, we=0; vreg[0..3]=those values; done at T+7, result=0.
//  2 After 1: VDOT ins=0xE000, rdata 1,2,3,4 -> done with result=0x01FE.
//  3 As 1 but gnt=0 for 3 cycles at element 1
//    -> req and addr hold at 0x0102 for those cycles; done at T+10.
//  4 VST ins=0xD010, base=0xFFFC
//    -> addr 0xFFFC,0xFFFE,0x0000,0x0002, we=1, wdata=vreg[i]; done at T+5.
//  5 vreg all 0xFFFF, VDOT with rdata all 0xFFFF
//    -> result=0x0004 (each product truncates to 1).
//  6 ins=0x0000 -> done+illegal at T+1, result=0.
//    Then VLD with rst_n=0 at T+3 -> IDLE, ins_ready=1, vreg=0; late rvalids ignored.

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: sequences VLD/VST/VDOT vector ops over one shared 16-bit memory port
//   clk, rst_n           clock and synchronous active-low reset
//   ins_valid/ins_ready  instruction handshake; ins[15:12] is the opcode, base_addr the vector base
//   mem_*                request/grant memory port; reads return in order via mem_rvalid/mem_rdata
//   done/result/illegal  one-cycle completion pulse, VDOT sum, non-vector opcode flag
//   vreg_sel/vreg_data   combinational debug read of the vector register file
module vec_mem_sequencer #(
    parameter int VLEN   = 4,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ins_valid,
    output logic                    ins_ready,
    input  logic [15:0]             ins,
    input  logic [15:0]             base_addr,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    done,
    output logic [DATA_W-1:0]       result,
    output logic                    illegal,
    input  logic [$clog2(VLEN)-1:0] vreg_sel,
    output logic [DATA_W-1:0]       vreg_data
);
    localparam int IW = $clog2(VLEN);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST = CW'(VLEN - 1);
    localparam logic [3:0] OP_VLD = 4'hC;
    localparam logic [3:0] OP_VST = 4'hD;
    localparam logic [3:0] OP_VDOT = 4'hE;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state;
    logic [3:0] op;
    logic [15:0] base;
    logic [CW-1:0] idx, ret, outstanding;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] vreg [VLEN];
    logic [3:0] opc;
    logic is_vec, grant, take, unused_ins;
    always_comb begin
        opc = ins[15:12];
        is_vec = opc == OP_VLD || opc == OP_VST || opc == OP_VDOT;
        grant = mem_req && mem_gnt;
        // only read data we actually asked for in this op is consumed; strays after a reset are dropped
        take = mem_rvalid && (state == ISSUE || state == DRAIN) && op != OP_VST && outstanding != '0;
        acc_nxt = acc + mem_rdata * vreg[ret[IW-1:0]];
    end
    assign unused_ins = ^ins[11:0];
    assign ins_ready = state == IDLE;
    assign mem_addr = base + 16'({idx, 1'b0});
    assign mem_wdata = (mem_req && mem_we) ? vreg[idx[IW-1:0]] : '0;
    assign vreg_data = vreg[vreg_sel];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op <= '0;
            base <= '0;
            idx <= '0;
            ret <= '0;
            outstanding <= '0;
            acc <= '0;
            vreg <= '{default: '0};
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            done <= 1'b0;
            result <= '0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            result <= '0;
            illegal <= 1'b0;
            // a same-cycle read grant and consumed rvalid cancel out
            outstanding <= outstanding + CW'(grant && op != OP_VST) - CW'(take);
            if (take) begin
                ret <= ret + 1'b1;
                if (op == OP_VLD) vreg[ret[IW-1:0]] <= mem_rdata;
                if (op == OP_VDOT) acc <= acc_nxt;
            end
            if (grant) idx <= idx + 1'b1;
            case (state)
                IDLE: if (ins_valid) begin
                    if (is_vec) begin
                        op <= opc;
                        base <= base_addr;
                        idx <= '0;
                        ret <= '0;
                        acc <= '0;
                        outstanding <= '0;
                        mem_req <= 1'b1;
                        mem_we <= opc == OP_VST;
                        state <= ISSUE;
                    end else begin
                        done <= 1'b1;
                        illegal <= 1'b1;
                        state <= DONE;
                    end
                end
                ISSUE: if (grant && idx == LAST) begin
                    mem_req <= 1'b0;
                    mem_we <= 1'b0;
                    done <= op == OP_VST;
                    state <= op == OP_VST ? DONE : DRAIN;
                end
                DRAIN: if (take && ret == LAST) begin
                    done <= 1'b1;
                    result <= op == OP_VDOT ? acc_nxt : '0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed bench for vec_mem_sequencer with an in-order memory responder
//   grants are driven per cycle, read data returns two cycles after each read grant
module tb_vec_mem_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ins_valid = 1'b0;
    logic mem_gnt = 1'b0;
    logic mem_rvalid = 1'b0;
    logic [15:0] ins = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] mem_rdata = '0;
    logic [1:0] vreg_sel = '0;
    logic ins_ready, mem_req, mem_we, done, illegal;
    logic [15:0] mem_addr, mem_wdata, result, vreg_data;

    vec_mem_sequencer #(.VLEN(4), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins(ins), .base_addr(base_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .done(done), .result(result),
        .illegal(illegal), .vreg_sel(vreg_sel), .vreg_data(vreg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] rdq [4];
    logic [15:0] g_addr [8];
    logic [15:0] g_wdata [8];
    logic g_we [8];
    logic [15:0] st_addr [8];
    logic st_req [8];
    int ngr, nst, done_at;
    logic [15:0] res;
    logic ill;

    // Offers one instruction, serves the memory port and records what the DUT did.
    // done_at is the edge count after accept at which done is sampled high.
    task automatic run_op(input logic [15:0] i, input logic [15:0] b, input int stall_at, input int stall_n);
        int due_q[$];
        int nrv;
        int dummy;
        nrv = 0;
        @(negedge clk);
        checks++;
        if (ins_ready !== 1'b1) begin errors++; $display("FAIL ready_idle got %b exp 1", ins_ready); end
        ins_valid = 1'b1;
        ins = i;
        base_addr = b;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        ngr = 0;
        nst = 0;
        done_at = -1;
        res = 'x;
        ill = 1'bx;
        for (int n = 0; n < 40 && done_at < 0; n++) begin
            @(negedge clk);
            ins_valid = 1'b0;
            ins = '0;
            if (done === 1'b1) begin
                done_at = n + 1;
                res = result;
                ill = illegal;
                mem_gnt = 1'b0;
                mem_rvalid = 1'b0;
            end else begin
                if (n == 0) begin
                    checks++;
                    if (ins_ready !== 1'b0) begin errors++; $display("FAIL ready_busy got %b exp 0", ins_ready); end
                end
                mem_rvalid = due_q.size() > 0 && due_q[0] == n + 1;
                if (mem_rvalid) begin
                    dummy = due_q.pop_front();
                    mem_rdata = rdq[nrv % 4];
                    nrv++;
                end else mem_rdata = '0;
                mem_gnt = 1'b0;
                if (ngr == stall_at && nst < stall_n) begin
                    st_addr[nst] = mem_addr;
                    st_req[nst] = mem_req;
                    nst++;
                end else if (mem_req === 1'b1) begin
                    mem_gnt = 1'b1;
                    if (ngr < 8) begin
                        g_addr[ngr] = mem_addr;
                        g_we[ngr] = mem_we;
                        g_wdata[ngr] = mem_wdata;
                    end
                    ngr++;
                    if (!mem_we) due_q.push_back(n + 3);
                end
            end
        end
        if (done_at < 0) begin checks++; errors++; $display("FAIL done_timeout ins=%h got none exp done", i); end
    endtask

    task automatic check_vregs(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3, input string tag);
        logic [15:0] exp_v [4];
        exp_v = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            vreg_sel = 2'(k);
            #1;
            checks++;
            if (vreg_data !== exp_v[k]) begin errors++; $display("FAIL %s vreg[%0d] got %h exp %h", tag, k, vreg_data, exp_v[k]); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({ins_ready, mem_req, mem_we, done, illegal} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 10000", {ins_ready, mem_req, mem_we, done, illegal});
        end
        checks++;
        if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
        check_vregs(16'h0, 16'h0, 16'h0, 16'h0, "reset");
    endtask

    task automatic test_vld();
        rdq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run_op(16'hC000, 16'h0100, -1, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g_addr[k] !== 16'h0100 + 16'(2 * k) || g_we[k] !== 1'b0) begin
                errors++; $display("FAIL vld_addr[%0d] got %h/%b exp %h/0", k, g_addr[k], g_we[k], 16'h0100 + 16'(2 * k));
            end
        end
        checks++;
        if (ngr !== 4) begin errors++; $display("FAIL vld_grants got %0d exp 4", ngr); end
        checks++;
        if (done_at !== 7) begin errors++; $display("FAIL vld_latency got %0d exp 7", done_at); end
        checks++;
        if (res !== 16'h0 || ill !== 1'b0) begin errors++; $display("FAIL vld_result got %h/%b exp 0000/0", res, ill); end
        check_vregs(16'h0011, 16'h0022, 16'h0033, 16'h0044, "vld");
    endtask

    task automatic test_vdot();
        rdq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        run_op(16'hE000, 16'h0100, -1, 0);
        checks++;
        if (done_at !== 7) begin errors++; $display("FAIL vdot_latency got %0d exp 7", done_at); end
        checks++;
        if (res !== 16'h01FE || ill !== 1'b0) begin errors++; $display("FAIL vdot_result got %h/%b exp 01fe/0", res, ill); end
        check_vregs(16'h0011, 16'h0022, 16'h0033, 16'h0044, "vdot_keep");
    endtask

    task automatic test_stall();
        rdq = '{16'h1055, 16'h2066, 16'h3077, 16'h4088};
        run_op(16'hC000, 16'h0100, 1, 3);
        checks++;
        if (nst !== 3) begin errors++; $display("FAIL stall_count got %0d exp 3", nst); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st_req[k] !== 1'b1 || st_addr[k] !== 16'h0102) begin
                errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/0102", k, st_req[k], st_addr[k]);
            end
        end
        checks++;
        if (g_addr[1] !== 16'h0102 || g_addr[3] !== 16'h0106) begin
            errors++; $display("FAIL stall_addr got %h,%h exp 0102,0106", g_addr[1], g_addr[3]);
        end
        checks++;
        if (done_at !== 10) begin errors++; $display("FAIL stall_latency got %0d exp 10", done_at); end
        check_vregs(16'h1055, 16'h2066, 16'h3077, 16'h4088, "stall");
    endtask

    task automatic test_vst();
        logic [15:0] ea [4];
        logic [15:0] ed [4];
        ea = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        ed = '{16'h1055, 16'h2066, 16'h3077, 16'h4088};
        run_op(16'hD010, 16'hFFFC, -1, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (g_addr[k] !== ea[k] || g_we[k] !== 1'b1 || g_wdata[k] !== ed[k]) begin
                errors++; $display("FAIL vst_elem[%0d] got %h/%b/%h exp %h/1/%h", k, g_addr[k], g_we[k], g_wdata[k], ea[k], ed[k]);
            end
        end
        checks++;
        if (done_at !== 5) begin errors++; $display("FAIL vst_latency got %0d exp 5", done_at); end
        checks++;
        if (res !== 16'h0 || ill !== 1'b0) begin errors++; $display("FAIL vst_result got %h/%b exp 0000/0", res, ill); end
    endtask

    task automatic test_vdot_wrap();
        rdq = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_op(16'hC000, 16'h0040, -1, 0);
        check_vregs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, "wrap_load");
        run_op(16'hE000, 16'h0040, -1, 0);
        checks++;
        if (res !== 16'h0004) begin errors++; $display("FAIL vdot_wrap got %h exp 0004", res); end
    endtask

    task automatic test_illegal();
        run_op(16'h0000, 16'h1234, -1, 0);
        checks++;
        if (done_at !== 1 || ill !== 1'b1 || res !== 16'h0) begin
            errors++; $display("FAIL illegal_0000 got t%0d/%b/%h exp t1/1/0000", done_at, ill, res);
        end
        checks++;
        if (ngr !== 0) begin errors++; $display("FAIL illegal_noreq got %0d exp 0", ngr); end
        run_op(16'hF123, 16'h0000, -1, 0);
        checks++;
        if (done_at !== 1 || ill !== 1'b1) begin errors++; $display("FAIL illegal_f123 got t%0d/%b exp t1/1", done_at, ill); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ins_valid = 1'b1;
        ins = 16'hC000;
        base_addr = 16'h0200;
        @(posedge clk);
        @(negedge clk);
        ins_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hABCD;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({ins_ready, mem_req, done} !== 3'b100) begin errors++; $display("FAIL rstmid_state got %b exp 100", {ins_ready, mem_req, done}); end
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt = 1'b0;
        #1;
        checks++;
        if ({ins_ready, mem_req, done, illegal} !== 4'b1000) begin
            errors++; $display("FAIL rstmid_idle got %b exp 1000", {ins_ready, mem_req, done, illegal});
        end
        check_vregs(16'h0, 16'h0, 16'h0, 16'h0, "rstmid");
        rdq = '{16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
        run_op(16'hC000, 16'h0300, -1, 0);
        checks++;
        if (done_at !== 7 || g_addr[0] !== 16'h0300) begin errors++; $display("FAIL rstmid_next got t%0d/%h exp t7/0300", done_at, g_addr[0]); end
        check_vregs(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, "rstmid_next");
    endtask

    initial begin
        test_reset();
        test_vld();
        test_vdot();
        test_stall();
        test_vst();
        test_vdot_wrap();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
